// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width, window
// tap indices (row-major, TL=0 .. BR=8), streaming phase type, counter widths.
package window_gen_3x3_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam int WIN_TL   = 0;
    localparam int WIN_TC   = 1;
    localparam int WIN_TR   = 2;
    localparam int WIN_ML   = 3;
    localparam int WIN_MC   = 4;
    localparam int WIN_MR   = 5;
    localparam int WIN_BL   = 6;
    localparam int WIN_BC   = 7;
    localparam int WIN_BR   = 8;
    localparam int WIN_SIZE = 9;

    typedef enum logic {
        PH_FILL   = 1'b0,
        PH_STREAM = 1'b1
    } phase_e;

    // Width of a counter that spans 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_delay.sv
// Shift-enabled delay line: o_data is the value presented DEPTH enabled beats
// earlier. Contents are not reset; the consumer gates start-up garbage.
module line_delay
    import window_gen_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 28
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator emitting only fully-populated windows.
// Optional frame_done pulse is enabled by defining WINDOW_GEN_FRAME_DONE_EN.
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic [DATA_WIDTH-1:0] data_out4,
    output logic [DATA_WIDTH-1:0] data_out5,
    output logic [DATA_WIDTH-1:0] data_out6,
    output logic [DATA_WIDTH-1:0] data_out7,
    output logic [DATA_WIDTH-1:0] data_out8,
`ifdef WINDOW_GEN_FRAME_DONE_EN
    output logic                  frame_done,
`endif
    output logic                  valid_out
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [DATA_WIDTH-1:0] w_line1;
    logic [DATA_WIDTH-1:0] w_line2;
    logic [DATA_WIDTH-1:0] r_win      [WIN_SIZE];
    logic [DATA_WIDTH-1:0] w_win_next [WIN_SIZE];
    logic [DATA_WIDTH-1:0] r_out      [WIN_SIZE];
    logic                  r_valid;
    phase_e                w_phase;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_qual;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_phase    = (r_row >= ROW_W'(2)) ? PH_STREAM : PH_FILL;
    assign w_qual     = valid_in && (w_phase == PH_STREAM) && (r_col >= COL_W'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (valid_in) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_line1 (
        .clk    (clk),
        .i_en   (valid_in && !rst),
        .i_data (data_in),
        .o_data (w_line1)
    );

    line_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_line2 (
        .clk    (clk),
        .i_en   (valid_in && !rst),
        .i_data (w_line1),
        .o_data (w_line2)
    );

    // Each window row shifts left; the new right column comes from the two
    // line delays (rows r-2, r-1) and the incoming pixel (row r).
    always_comb begin
        w_win_next[WIN_TL] = r_win[WIN_TC];
        w_win_next[WIN_TC] = r_win[WIN_TR];
        w_win_next[WIN_TR] = w_line2;
        w_win_next[WIN_ML] = r_win[WIN_MC];
        w_win_next[WIN_MC] = r_win[WIN_MR];
        w_win_next[WIN_MR] = w_line1;
        w_win_next[WIN_BL] = r_win[WIN_BC];
        w_win_next[WIN_BC] = r_win[WIN_BR];
        w_win_next[WIN_BR] = data_in;
    end

    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            r_win <= w_win_next;
        end
    end

    // Outputs are a separate copy so they hold between windows even though
    // the shifting window keeps moving through columns 0-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            r_valid <= w_qual;
            if (w_qual) begin
                r_out <= w_win_next;
            end
        end
    end

`ifdef WINDOW_GEN_FRAME_DONE_EN
    logic r_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_qual && w_col_last && w_row_last;
        end
    end

    assign frame_done = r_frame_done;
`endif

    assign valid_out = r_valid;
    assign data_out0 = r_out[WIN_TL];
    assign data_out1 = r_out[WIN_TC];
    assign data_out2 = r_out[WIN_TR];
    assign data_out3 = r_out[WIN_ML];
    assign data_out4 = r_out[WIN_MC];
    assign data_out5 = r_out[WIN_MR];
    assign data_out6 = r_out[WIN_BL];
    assign data_out7 = r_out[WIN_BC];
    assign data_out8 = r_out[WIN_BR];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 instance for directed and random frames and
// a 28x28 instance for a full random frame, both against a frame-array model.
module tb_window_gen_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dataIn = '0;
    logic        vinS = 1'b0;
    logic        vinB = 1'b0;
    logic [31:0] dS [9];
    logic [31:0] dB [9];
    logic        valS, valB;
`ifdef WINDOW_GEN_FRAME_DONE_EN
    logic        fdS, fdB;
`endif

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dutS (
        .clk(clk), .rst(rst), .data_in(dataIn), .valid_in(vinS),
        .data_out0(dS[0]), .data_out1(dS[1]), .data_out2(dS[2]),
        .data_out3(dS[3]), .data_out4(dS[4]), .data_out5(dS[5]),
        .data_out6(dS[6]), .data_out7(dS[7]), .data_out8(dS[8]),
`ifdef WINDOW_GEN_FRAME_DONE_EN
        .frame_done(fdS),
`endif
        .valid_out(valS)
    );

    window_gen_3x3 #(.DATA_WIDTH(32), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dutB (
        .clk(clk), .rst(rst), .data_in(dataIn), .valid_in(vinB),
        .data_out0(dB[0]), .data_out1(dB[1]), .data_out2(dB[2]),
        .data_out3(dB[3]), .data_out4(dB[4]), .data_out5(dB[5]),
        .data_out6(dB[6]), .data_out7(dB[7]), .data_out8(dB[8]),
`ifdef WINDOW_GEN_FRAME_DONE_EN
        .frame_done(fdB),
`endif
        .valid_out(valB)
    );

    // Reference model: per instance, the current frame as a 2-D array plus
    // the raster position of the next pixel and the last emitted window.
    int           wid [2] = '{4, 28};
    int           hgt [2] = '{4, 28};
    int           rowM [2];
    int           colM [2];
    logic [31:0]  img [2][28][28];
    logic [287:0] hold [2];

    int           testsRun = 0;
    int           testsFailed = 0;
    int           pulseCnt = 0;
    logic [287:0] wins [$];

    task automatic checkOutput(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Window whose top-left pixel value is base, in a frame filled with
    // consecutive integers and row width w.
    function automatic logic [287:0] mkWin(input int base, input int w);
        logic [287:0] v;
        for (int k = 0; k < 9; k++) begin
            v[287 - 32*k -: 32] = 32'(base + (k / 3) * w + (k % 3));
        end
        return v;
    endfunction

    task automatic applyStimulus(input bit big, input logic [31:0] pix, input bit vin, input bit doRst);
        int s;
        int r;
        int c;
        bit expValid;
        bit expFd;
        bit obsValid;
        logic [287:0] obsWin;
        s = big ? 1 : 0;
        rst = doRst;
        dataIn = pix;
        vinS = vin && !big;
        vinB = vin && big;
        @(posedge clk);
        expValid = 1'b0;
        expFd = 1'b0;
        if (doRst) begin
            for (int i = 0; i < 2; i++) begin
                rowM[i] = 0;
                colM[i] = 0;
                hold[i] = '0;
            end
        end else if (vin) begin
            r = rowM[s];
            c = colM[s];
            img[s][r][c] = pix;
            if (r >= 2 && c >= 2) begin
                expValid = 1'b1;
                expFd = (r == hgt[s] - 1) && (c == wid[s] - 1);
                for (int k = 0; k < 9; k++) begin
                    hold[s][287 - 32*k -: 32] = img[s][r - 2 + k / 3][c - 2 + k % 3];
                end
            end
            colM[s] = c + 1;
            if (colM[s] == wid[s]) begin
                colM[s] = 0;
                rowM[s] = (r + 1 == hgt[s]) ? 0 : r + 1;
            end
        end
        #1;
        for (int k = 0; k < 9; k++) begin
            obsWin[287 - 32*k -: 32] = big ? dB[k] : dS[k];
        end
        obsValid = big ? valB : valS;
        checkOutput(big ? "validB" : "validS", {287'd0, obsValid}, {287'd0, expValid});
        checkOutput(big ? "windowB" : "windowS", obsWin, hold[s]);
`ifdef WINDOW_GEN_FRAME_DONE_EN
        checkOutput(big ? "frameDoneB" : "frameDoneS", {287'd0, big ? fdB : fdS}, {287'd0, expFd});
`endif
        if (obsValid) begin
            pulseCnt++;
            wins.push_back(obsWin);
        end
        rst = 1'b0;
        vinS = 1'b0;
        vinB = 1'b0;
    endtask

    task automatic startTest();
        pulseCnt = 0;
        wins.delete();
    endtask

    initial begin
        int fed;

        // Reset state, including reset winning over a same-cycle pixel.
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // Continuous 4x4 frame of 0..15.
        startTest();
        for (int p = 0; p < 16; p++) applyStimulus(1'b0, 32'(p), 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pulsesContinuous", 288'(pulseCnt), 288'd4);
        if (wins.size() == 4) begin
            checkOutput("firstWindow", wins[0], mkWin(0, 4));
            checkOutput("lastWindow", wins[3], mkWin(5, 4));
        end else begin
            checkOutput("windowCount", 288'(wins.size()), 288'd4);
        end

        // Same frame with a gap after every pixel.
        startTest();
        for (int p = 0; p < 16; p++) begin
            applyStimulus(1'b0, 32'(p), 1'b1, 1'b0);
            applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
        end
        checkOutput("pulsesGapped", 288'(pulseCnt), 288'd4);
        if (wins.size() == 4) checkOutput("gappedFirst", wins[0], mkWin(0, 4));

        // Two back-to-back frames.
        startTest();
        for (int p = 0; p < 16; p++) applyStimulus(1'b0, 32'(p), 1'b1, 1'b0);
        for (int p = 0; p < 16; p++) applyStimulus(1'b0, 32'(100 + p), 1'b1, 1'b0);
        checkOutput("pulsesTwoFrames", 288'(pulseCnt), 288'd8);
        if (wins.size() == 8) checkOutput("frame2First", wins[4], mkWin(100, 4));

        // Reset after pixel 9, then a fresh frame.
        startTest();
        for (int p = 0; p < 10; p++) applyStimulus(1'b0, 32'(p), 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h1234_5678, 1'b1, 1'b1);
        checkOutput("pulsesBeforeRestart", 288'(pulseCnt), 288'd0);
        for (int p = 0; p < 16; p++) applyStimulus(1'b0, 32'(p), 1'b1, 1'b0);
        checkOutput("pulsesAfterRestart", 288'(pulseCnt), 288'd4);
        if (wins.size() == 4) checkOutput("restartLast", wins[3], mkWin(5, 4));

        // Random 4x4 traffic with gaps and occasional resets.
        for (int n = 0; n < 200; n++) begin
            applyStimulus(1'b0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
        end

        // Full random 28x28 frame with gaps.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b1);
        startTest();
        fed = 0;
        while (fed < 28 * 28) begin
            if ($urandom_range(0, 4) != 0) begin
                applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
                fed++;
            end else begin
                applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
            end
        end
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("pulsesBigFrame", 288'(pulseCnt), 288'd676);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 window generator: accepts one raster-order pixel per `valid_in` beat and emits the nine-pixel neighbourhood on nine parallel outputs with `valid_out`. It sits directly upstream of the 3x3 convolution pipeline and drives that pipeline's `data_in0..data_in8` / `valid_in` ports. It produces valid (unpadded) windows only: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame. Pixel data is transported bit-exact; no arithmetic is performed on it.

## Interface
- `DATA_WIDTH`, 32: pixel width (IEEE-754 single bit pattern, opaque here).
- `IMG_WIDTH`, 28: pixels per row, ≥3.
- `IMG_HEIGHT`, 28: rows per frame, ≥3.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `data_in`  in  DATA_WIDTH  pixel, raster order, row-major.
- `valid_in`  in  1  `data_in` accepted this cycle; no backpressure.
- `data_out0`..`data_out8`  out  DATA_WIDTH each  window, row-major: 0 = top-left (row r-2, col c-2), 4 = centre, 8 = bottom-right (current pixel).
- `valid_out`  out  1  window on `data_out0..8` is valid this cycle.
- `frame_done`  out  1  only with `WINDOW_GEN_FRAME_DONE_EN`; see Configuration.

## Operation
- Column counter `col` (0..IMG_WIDTH-1) and row counter `row` (0..IMG_HEIGHT-1) advance only on `valid_in`; `col` wraps to 0 and increments `row`; after (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 (next frame).
- Two line delays, each IMG_WIDTH deep: line 1 delays `data_in` by one row, line 2 delays line-1 output by one more row. Both shift only on `valid_in`.
- 3x3 window register: on `valid_in`, each of the three window rows shifts left one column; new right column = {line-2 out, line-1 out, `data_in`} for top/middle/bottom.
- Phases: FILL while `row` < 2 (no output); STREAM while `row` ≥ 2. Window emitted when accepted pixel has `row` ≥ 2 and `col` ≥ 2.
- Columns 0-1 of each row never emit (window still holds previous row's tail); rows 0-1 of each frame never emit even though line buffers hold previous-frame data.
- `valid_in` gaps: all state holds; no spurious output.

## Timing
- Latency 1: pixel (r,c) accepted at edge t qualifies → at cycle t+1 `valid_out`=1 and outputs hold rows r-2..r, cols c-2..c.
- `valid_out` is a single-cycle pulse per window; back-to-back for consecutive qualifying pixels.
- When `valid_out`=0, `data_out0..8` hold their last value.
- Reset: `valid_out`=0, `frame_done`=0, all `data_out*`=0, `col`=`row`=0. Line-buffer contents need not be cleared (gated by FILL).
- Reset mid-frame: next accepted pixel is (0,0) of a new frame; no window emitted until row 2 col 2 of that frame.
- `rst` and `valid_in` same cycle: reset wins; pixel dropped.

## Configuration
- `WINDOW_GEN_FRAME_DONE_EN` defined: `frame_done` port exists, asserted in the same cycle as the `valid_out` of the last window of a frame (pixel (IMG_HEIGHT-1, IMG_WIDTH-1)), reset 0, one-cycle pulse.
- Undefined: no `frame_done` port; no extra logic. All other behaviour identical.

## Structure
- Shared package: default `DATA_WIDTH`, window index constants (TL=0 … BR=8), `$clog2`-derived counter widths as localparams/functions.
- Sub-module `line_delay`: parameterised DATA_WIDTH/DEPTH, shift-enable delay line; instantiated twice.
- Counters, FILL/STREAM qualification and window registers live in the top.

## Test plan
- IMG_WIDTH=IMG_HEIGHT=4, pixels 0..15 continuous `valid_in` → exactly 4 `valid_out` pulses; first window = 0,1,2,4,5,6,8,9,10; last = 5,6,7,9,10,11,13,14,15.
- Same frame with `valid_in` low every other cycle → identical 4 windows, outputs hold between pulses.
- Two back-to-back frames (0..15 then 100..115) → 8 windows; second frame's first window = 100,101,102,104,105,106,108,109,110; no window during rows 0-1 of frame 2.
- `rst` asserted after pixel 9, then pixels 0..15 → no output before restart; then the 4 standard windows; all outputs 0 during reset.
- 28x28 random data vs software reference → 676 windows, bit-exact, 1-cycle latency.
- With `WINDOW_GEN_FRAME_DONE_EN`, 4x4 frame → `frame_done` high only with the 4th window.
